// File: rtl/sw_result_collector.sv
// Reduces the per-target Smith-Waterman score stream to one record per query and buffers
// the records in a first-word-fall-through FIFO. Optional threshold filter: SW_COLLECT_THRESH_EN.
module sw_result_collector #(
  parameter int CALC_W     = 16,
  parameter int IDX_W      = 10,
  parameter int QID_W      = 8,
  parameter int CNT_W      = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic [CALC_W-1:0]           score_i,
  input  logic                        valid_i,
  input  logic [IDX_W-1:0]            t_idx_i,
  input  logic                        change_q_i,
`ifdef SW_COLLECT_THRESH_EN
  input  logic [CALC_W-1:0]           thresh_i,
`endif
  output logic                        rec_valid_o,
  input  logic                        rec_ready_i,
  output logic [QID_W-1:0]            rec_qid_o,
  output logic [CALC_W-1:0]           rec_score_o,
  output logic [IDX_W-1:0]            rec_tidx_o,
  output logic [CNT_W-1:0]            rec_count_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        overflow_o,
  output logic                        busy_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int REC_W = QID_W + CALC_W + IDX_W + CNT_W;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {ST_ACCUM = 1'b0, ST_CLOSE = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              close_fire;
  logic [QID_W-1:0]  qid_q, qid_d;
  logic [CALC_W-1:0] best_q, best_d, base_best;
  logic [IDX_W-1:0]  tidx_q, tidx_d, base_tidx;
  logic [CNT_W-1:0]  cnt_q, cnt_d, base_cnt;

  logic [REC_W-1:0]  mem_q [FIFO_DEPTH];
  logic [REC_W-1:0]  head;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              thresh_ok, push_req, push_ok, pop, full, drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: if (change_q_i) state_d = ST_CLOSE;
      ST_CLOSE: state_d = change_q_i ? ST_CLOSE : ST_ACCUM;
      default:  state_d = ST_ACCUM;
    endcase
    if (start_i) state_d = ST_ACCUM;
  end

  always_comb begin
    close_fire = (state_q == ST_CLOSE);
  end

  // In CLOSE the registers still hold the finished query; a beat that cycle starts afresh.
  always_comb begin
    base_best = close_fire ? '0 : best_q;
    base_tidx = close_fire ? '0 : tidx_q;
    base_cnt  = close_fire ? '0 : cnt_q;
    best_d    = base_best;
    tidx_d    = base_tidx;
    cnt_d     = base_cnt;
    qid_d     = close_fire ? qid_q + QID_W'(1) : qid_q;
    if (valid_i) begin
      if (base_cnt != CNT_MAX) cnt_d = base_cnt + CNT_W'(1);
      if (score_i > base_best) begin
        best_d = score_i;
        tidx_d = t_idx_i;
      end
    end
    if (start_i) begin
      best_d = '0;
      tidx_d = '0;
      cnt_d  = '0;
      qid_d  = '0;
    end
  end

`ifdef SW_COLLECT_THRESH_EN
  assign thresh_ok = (best_q >= thresh_i);
`else
  assign thresh_ok = 1'b1;
`endif

  assign full     = (level_q == LVL_FULL);
  assign pop      = (level_q != '0) && rec_ready_i;
  assign push_req = close_fire && !start_i && thresh_ok;
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | drop;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop)      level_d = level_q + LVL_W'(1);
    else if (!push_ok && pop) level_d = level_q - LVL_W'(1);
    if (start_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qid_q      <= '0;
      best_q     <= '0;
      tidx_q     <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      qid_q      <= qid_d;
      best_q     <= best_d;
      tidx_q     <= tidx_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {qid_q, best_q, tidx_q, cnt_q};
  end

  assign head        = mem_q[rd_ptr_q];
  assign rec_valid_o = (level_q != '0);
  assign {rec_qid_o, rec_score_o, rec_tidx_o, rec_count_o} = rec_valid_o ? head : '0;
  assign level_o     = level_q;
  assign overflow_o  = overflow_q;
  assign busy_o      = (cnt_q != '0) || (level_q != '0);

endmodule

// File: tb/tb_sw_result_collector.sv
// Self-checking bench for sw_result_collector: a query-reduction model feeds a record
// scoreboard that is compared against the FIFO head as records are drained.
`timescale 1ns/1ps
module tb_sw_result_collector;
  localparam int CALC_W = 16;
  localparam int IDX_W  = 10;
  localparam int QID_W  = 8;
  localparam int CNT_W  = 10;
  localparam int DEPTH  = 8;

  typedef struct packed {
    logic [QID_W-1:0]  qid;
    logic [CALC_W-1:0] score;
    logic [IDX_W-1:0]  tidx;
    logic [CNT_W-1:0]  cnt;
  } rec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic [CALC_W-1:0] score_i = '0;
  logic              valid_i = 1'b0;
  logic [IDX_W-1:0]  t_idx_i = '0;
  logic              change_q_i = 1'b0;
`ifdef SW_COLLECT_THRESH_EN
  logic [CALC_W-1:0] thresh_i = '0;
`endif
  logic              rec_ready_i = 1'b0;
  logic              rec_valid_o;
  logic [QID_W-1:0]  rec_qid_o;
  logic [CALC_W-1:0] rec_score_o;
  logic [IDX_W-1:0]  rec_tidx_o;
  logic [CNT_W-1:0]  rec_count_o;
  logic [3:0]        level_o;
  logic              overflow_o;
  logic              busy_o;
  rec_t              head_now;

  rec_t              sb[$];
  rec_t              last_popped;
  logic [QID_W-1:0]  m_qid;
  logic [CALC_W-1:0] m_best;
  logic [IDX_W-1:0]  m_tidx;
  logic [CNT_W-1:0]  m_cnt;
  int                n_checks = 0;
  int                n_fail = 0;

  sw_result_collector #(
    .CALC_W(CALC_W), .IDX_W(IDX_W), .QID_W(QID_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .score_i(score_i), .valid_i(valid_i),
    .t_idx_i(t_idx_i), .change_q_i(change_q_i),
`ifdef SW_COLLECT_THRESH_EN
    .thresh_i(thresh_i),
`endif
    .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i), .rec_qid_o(rec_qid_o),
    .rec_score_o(rec_score_o), .rec_tidx_o(rec_tidx_o), .rec_count_o(rec_count_o),
    .level_o(level_o), .overflow_o(overflow_o), .busy_o(busy_o)
  );

  assign head_now = {rec_qid_o, rec_score_o, rec_tidx_o, rec_count_o};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    sb.delete();
    m_qid  = '0;
    m_best = '0;
    m_tidx = '0;
    m_cnt  = '0;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    model_reset();
  endtask

  // One input cycle; when it closes a query, optionally pops the head during the CLOSE cycle.
  task automatic step(input bit v, input logic [CALC_W-1:0] s, input logic [IDX_W-1:0] t,
                      input bit cq, input bit pop_in_close);
    rec_t r;
    bit   keep;
    valid_i = v; score_i = s; t_idx_i = t; change_q_i = cq;
    tick();
    valid_i = 1'b0; change_q_i = 1'b0;
    if (v) begin
      if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
      if (s > m_best) begin
        m_best = s;
        m_tidx = t;
      end
    end
    if (cq) begin
      if (pop_in_close) begin
        last_popped = head_now;
        rec_ready_i = 1'b1;
        tick();
        rec_ready_i = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
      end
      r.qid = m_qid; r.score = m_best; r.tidx = m_tidx; r.cnt = m_cnt;
      keep = 1'b1;
`ifdef SW_COLLECT_THRESH_EN
      keep = (m_best >= thresh_i);
`endif
      if (keep && sb.size() < DEPTH) sb.push_back(r);
      m_qid = m_qid + 1'b1;
      m_best = '0; m_tidx = '0; m_cnt = '0;
    end
  endtask

  task automatic pop_rec(output rec_t r, output bit ok);
    ok = 1'b0;
    r  = '0;
    for (int i = 0; i < 20; i++) begin
      if (rec_valid_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      r = head_now;
      rec_ready_i = 1'b1;
      tick();
      rec_ready_i = 1'b0;
      $display("rec qid=%0d score=%0d tidx=%0d cnt=%0d", r.qid, r.score, r.tidx, r.cnt);
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    n_checks++;
    if ({rec_valid_o, level_o, overflow_o, busy_o, head_now} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got valid=%0b level=%0d ovf=%0b busy=%0b head=%h, expected all 0",
               rec_valid_o, level_o, overflow_o, busy_o, head_now);
    end
    rst_n = 1'b1;
    model_reset();
    tick();
    n_checks++;
    if ({rec_valid_o, level_o, overflow_o, busy_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got valid=%0b level=%0d ovf=%0b busy=%0b, expected 0",
               rec_valid_o, level_o, overflow_o, busy_o);
    end
  endtask

  task automatic test_basic();
    rec_t got, exp, lit;
    bit   ok;
    step(1, 16'd5, 10'd0, 0, 0);
    step(1, 16'd9, 10'd1, 0, 0);
    step(1, 16'd9, 10'd2, 0, 0);
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy: got %0b expected 1", busy_o);
    end
    step(1, 16'd3, 10'd3, 1, 0);
    n_checks++;
    if (rec_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_latency_n1: rec_valid got %0b expected 0", rec_valid_o);
    end
    tick();
    n_checks++;
    if (rec_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL basic_latency_n2: rec_valid got %0b expected 1", rec_valid_o);
    end
    lit.qid = 8'd0; lit.score = 16'd9; lit.tidx = 10'd1; lit.cnt = 10'd4;
    n_checks++;
    if (head_now !== lit) begin
      n_fail++; $display("FAIL basic_head: got %h expected %h", head_now, lit);
    end
    pop_rec(got, ok);
    exp = (sb.size() > 0) ? sb.pop_front() : '1;
    n_checks++;
    if (!ok || got !== exp) begin
      n_fail++; $display("FAIL basic_pop: ok=%0b got %h expected %h", ok, got, exp);
    end
    n_checks++;
    if ({level_o, busy_o} !== '0) begin
      n_fail++; $display("FAIL basic_idle: level=%0d busy=%0b expected 0 0", level_o, busy_o);
    end
  endtask

  task automatic test_empty_query();
    rec_t got, exp;
    bit   ok;
    step(0, '0, '0, 1, 0);
    tick();
    n_checks++;
    if (level_o !== 4'd1) begin
      n_fail++; $display("FAIL empty_level: got %0d expected 1", level_o);
    end
    pop_rec(got, ok);
    exp = (sb.size() > 0) ? sb.pop_front() : '1;
    n_checks++;
    if (!ok || got !== exp || got.qid !== 8'd1) begin
      n_fail++; $display("FAIL empty_record: ok=%0b got %h expected %h", ok, got, exp);
    end
  endtask

  task automatic test_back_to_back();
    rec_t got, exp;
    bit   ok;
    step(1, 16'd20, 10'd3, 1, 0);
    step(0, '0, '0, 1, 0);
    step(1, 16'd2, 10'd4, 0, 0);
    step(0, '0, '0, 1, 0);
    tick(); tick();
    n_checks++;
    if (level_o !== 4'd3) begin
      n_fail++; $display("FAIL b2b_level: got %0d expected 3", level_o);
    end
    for (int i = 0; i < 3; i++) begin
      pop_rec(got, ok);
      exp = (sb.size() > 0) ? sb.pop_front() : '1;
      n_checks++;
      if (!ok || got !== exp) begin
        n_fail++; $display("FAIL b2b_rec[%0d]: ok=%0b got %h expected %h", i, ok, got, exp);
      end
    end
  endtask

  task automatic test_overflow();
    rec_t got, exp;
    bit   ok;
    do_start();
    for (int i = 0; i < 9; i++) begin
      step(1, CALC_W'(100 + i), IDX_W'(i), 1, 0);
      tick();
    end
    tick();
    n_checks++;
    if (level_o !== 4'd8 || overflow_o !== 1'b1 || rec_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_full: level=%0d ovf=%0b valid=%0b expected 8 1 1",
                         level_o, overflow_o, rec_valid_o);
    end
    for (int i = 0; i < 8; i++) begin
      pop_rec(got, ok);
      exp = (sb.size() > 0) ? sb.pop_front() : '1;
      n_checks++;
      if (!ok || got !== exp || got.qid !== QID_W'(i)) begin
        n_fail++; $display("FAIL ovf_drain[%0d]: ok=%0b got %h expected %h", i, ok, got, exp);
      end
    end
    n_checks++;
    if (level_o !== 4'd0 || overflow_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: level=%0d ovf=%0b expected 0 1", level_o, overflow_o);
    end
  endtask

  task automatic test_full_push_pop();
    rec_t got, exp, exp0;
    bit   ok;
    do_start();
    n_checks++;
    if (overflow_o !== 1'b0) begin
      n_fail++; $display("FAIL fpp_start_clears_ovf: got %0b expected 0", overflow_o);
    end
    for (int i = 0; i < 8; i++) begin
      step(1, CALC_W'(50 + i), IDX_W'(i), 1, 0);
      tick();
    end
    n_checks++;
    if (level_o !== 4'd8) begin
      n_fail++; $display("FAIL fpp_fill: level got %0d expected 8", level_o);
    end
    exp0 = sb[0];
    step(1, 16'd77, 10'd5, 1, 1);
    n_checks++;
    if (last_popped !== exp0) begin
      n_fail++; $display("FAIL fpp_pop_head: got %h expected %h", last_popped, exp0);
    end
    n_checks++;
    if (level_o !== 4'd8 || overflow_o !== 1'b0) begin
      n_fail++; $display("FAIL fpp_level: level=%0d ovf=%0b expected 8 0", level_o, overflow_o);
    end
    for (int i = 0; i < 8; i++) begin
      pop_rec(got, ok);
      exp = (sb.size() > 0) ? sb.pop_front() : '1;
      n_checks++;
      if (!ok || got !== exp) begin
        n_fail++; $display("FAIL fpp_drain[%0d]: ok=%0b got %h expected %h", i, ok, got, exp);
      end
    end
  endtask

  task automatic test_start_clear();
    rec_t got, exp;
    bit   ok;
    do_start();
    for (int i = 0; i < 3; i++) begin
      step(1, CALC_W'(i + 1), IDX_W'(i), 1, 0);
      tick();
    end
    step(1, 16'd30, 10'd2, 0, 0);
    start_i = 1'b1; change_q_i = 1'b1; valid_i = 1'b1; score_i = 16'd40; t_idx_i = 10'd6;
    tick();
    start_i = 1'b0; change_q_i = 1'b0; valid_i = 1'b0;
    model_reset();
    n_checks++;
    if ({rec_valid_o, level_o, overflow_o, busy_o} !== '0) begin
      n_fail++; $display("FAIL start_flush: valid=%0b level=%0d ovf=%0b busy=%0b expected 0",
                         rec_valid_o, level_o, overflow_o, busy_o);
    end
    tick(); tick();
    n_checks++;
    if (level_o !== 4'd0) begin
      n_fail++; $display("FAIL start_discard: level got %0d expected 0", level_o);
    end
    step(1, 16'd4, 10'd7, 1, 0);
    pop_rec(got, ok);
    exp = (sb.size() > 0) ? sb.pop_front() : '1;
    n_checks++;
    if (!ok || got !== exp || got.qid !== 8'd0) begin
      n_fail++; $display("FAIL start_next_qid: ok=%0b got %h expected %h", ok, got, exp);
    end
  endtask

`ifdef SW_COLLECT_THRESH_EN
  task automatic test_thresh();
    rec_t got, exp;
    bit   ok;
    do_start();
    thresh_i = 16'd10;
    step(1, 16'd9, 10'd0, 1, 0);  tick();
    step(1, 16'd10, 10'd1, 1, 0); tick();
    step(1, 16'd15, 10'd2, 1, 0); tick();
    tick();
    n_checks++;
    if (level_o !== 4'd2 || overflow_o !== 1'b0) begin
      n_fail++; $display("FAIL thresh_level: level=%0d ovf=%0b expected 2 0", level_o, overflow_o);
    end
    for (int i = 0; i < 2; i++) begin
      pop_rec(got, ok);
      exp = (sb.size() > 0) ? sb.pop_front() : '1;
      n_checks++;
      if (!ok || got !== exp || got.qid !== QID_W'(i + 1)) begin
        n_fail++; $display("FAIL thresh_rec[%0d]: ok=%0b got %h expected %h", i, ok, got, exp);
      end
    end
    thresh_i = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_empty_query();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_start_clear();
`ifdef SW_COLLECT_THRESH_EN
    test_thresh();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
